// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demux controllers.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Folds to constant 0 when the select width cannot encode an illegal lane.
    function automatic logic sel_out_of_range(input logic [31:0] sel, input int unsigned num_out);
        return sel >= num_out;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Single-entry output register with valid/ready handshake and one-hot lane decode.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [DATA_W-1:0]         load_data,
    input  logic                      load_last,
    input  logic [SEL_W-1:0]          load_dest,
    output logic                      can_load,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [SEL_W-1:0]  dest_q, dest_d;
    logic              ready_sel;
    logic              drain;

    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (dest_q == SEL_W'(i)) begin
                ready_sel = out_ready[i];
            end
        end
    end

    assign drain    = vld_q && ready_sel;
    assign can_load = !vld_q || ready_sel;

    // A load in the same cycle as a drain overwrites the entry and keeps it valid.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        dest_d = dest_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = load_data;
            last_d = load_last;
            dest_d = load_dest;
        end else if (drain) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
        end
    end

    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (vld_q && (dest_q == SEL_W'(i))) begin
                out_valid[i]                 = 1'b1;
                out_last[i]                  = last_q;
                out_data[i*DATA_W +: DATA_W] = data_q;
            end
        end
    end

endmodule

// File: rtl/demux_stream_scheduler.sv
// Packet-level 1-to-N demux controller: locks the route on the first beat, holds it to last.
module demux_stream_scheduler
    import demux_pkg::*;
#(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic                      busy,
    output logic                      sel_err
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] dest_lock_q, dest_lock_d;
    logic             sel_err_q, sel_err_d;
    logic             load;
    logic [SEL_W-1:0] load_dest;
    logic             can_load;
    logic             accept;
    logic             sel_bad;

    // Dropped packets never touch the register, so they are not throttled by it.
    assign in_ready = (state_q == DROP) || can_load;
    assign accept   = in_valid && in_ready;
    assign sel_bad  = sel_out_of_range(32'(in_sel), NUM_OUT);
    assign busy     = (state_q != IDLE);
    assign sel_err  = sel_err_q;

    always_comb begin
        state_d     = state_q;
        dest_lock_d = dest_lock_q;
        sel_err_d   = 1'b0;
        load        = 1'b0;
        load_dest   = dest_lock_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_bad) begin
                        sel_err_d = 1'b1;
                        state_d   = in_last ? IDLE : DROP;
                    end else begin
                        load        = 1'b1;
                        load_dest   = in_sel;
                        dest_lock_d = in_sel;
                        state_d     = in_last ? IDLE : ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dest_lock_q <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_lock_q <= dest_lock_d;
            sel_err_q   <= sel_err_d;
        end
    end

    demux_out_reg #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (in_data),
        .load_last (in_last),
        .load_dest (load_dest),
        .can_load  (can_load),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Scoreboard bench for demux_stream_scheduler with a 4-lane and a 3-lane instance.
module tb_demux_stream_scheduler;

   typedef struct packed {
      logic [3:0] lane;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;

   logic [7:0]  inData, inData3;
   logic [1:0]  inSel, inSel3;
   logic        inLast, inLast3;
   logic        inValid, inValid3;
   logic        inReady, inReady3;
   logic [31:0] outData;
   logic [23:0] outData3;
   logic [3:0]  outLast, outValid, outReady;
   logic [2:0]  outLast3, outValid3, outReady3;
   logic        busy, busy3, selErr, selErr3;

   int assertCount = 0;
   int failCount   = 0;

   beat_t sb4[$];
   beat_t sb3[$];
   beat_t exp4, exp3;
   logic [7:0] trace[$];
   bit traceOn = 0;

   int busyCycles4 = 0, lane2Valid4 = 0, lane2Last4 = 0;
   int selErrCount3 = 0, validCount3 = 0, selErrCount4 = 0;

   always #5 clk = ~clk;

   demux_stream_scheduler #(.NUM_OUT(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(inData), .in_sel(inSel), .in_last(inLast), .in_valid(inValid), .in_ready(inReady),
      .out_data(outData), .out_last(outLast), .out_valid(outValid), .out_ready(outReady),
      .busy(busy), .sel_err(selErr)
   );

   demux_stream_scheduler #(.NUM_OUT(3), .DATA_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(inData3), .in_sel(inSel3), .in_last(inLast3), .in_valid(inValid3), .in_ready(inReady3),
      .out_data(outData3), .out_last(outLast3), .out_valid(outValid3), .out_ready(outReady3),
      .busy(busy3), .sel_err(selErr3)
   );

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Offers one beat to the 4-lane instance and records its expected delivery once it is taken.
   task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel, input logic last,
                                input logic [3:0] lane);
      int    waitCycles;
      bit    done;
      beat_t b;
      waitCycles = 0;
      done       = 0;
      inData = data; inSel = sel; inLast = last; inValid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (inReady) begin
            b.lane = lane; b.data = data; b.last = last;
            sb4.push_back(b);
            done = 1;
         end else begin
            waitCycles++;
            if (waitCycles > 50) begin
               checkOutput("in_ready_timeout4", inReady, 1);
               done = 1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   // Same for the 3-lane instance; dropped beats expect no delivery.
   task automatic applyStimulus3(input logic [7:0] data, input logic [1:0] sel, input logic last,
                                 input logic [3:0] lane, input bit drop);
      int    waitCycles;
      bit    done;
      beat_t b;
      waitCycles = 0;
      done       = 0;
      inData3 = data; inSel3 = sel; inLast3 = last; inValid3 = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (inReady3) begin
            if (!drop) begin
               b.lane = lane; b.data = data; b.last = last;
               sb3.push_back(b);
            end
            done = 1;
         end else begin
            waitCycles++;
            if (waitCycles > 50) begin
               checkOutput("in_ready_timeout3", inReady3, 1);
               done = 1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idleInputs();
      inValid = 1'b0; inLast = 1'b0; inSel = '0; inData = '0;
      inValid3 = 1'b0; inLast3 = 1'b0; inSel3 = '0; inData3 = '0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor for the 4-lane instance: scoreboard pops plus idle-lane hygiene.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (outValid[i] && outReady[i]) begin
               checkOutput("sb4_has_entry", sb4.size() != 0, 1);
               if (sb4.size() != 0) begin
                  exp4 = sb4.pop_front();
                  checkOutput("sb4_lane", i, exp4.lane);
                  checkOutput("sb4_data", outData[i*8 +: 8], exp4.data);
                  checkOutput("sb4_last", outLast[i], exp4.last);
               end
            end
            if (!outValid[i]) begin
               checkOutput("idle_data4", outData[i*8 +: 8], 0);
               checkOutput("idle_last4", outLast[i], 0);
            end
         end
         checkOutput("onehot4", $countones(outValid) <= 1, 1);
         busyCycles4  += int'(busy);
         lane2Valid4  += int'(outValid[2]);
         lane2Last4   += int'(outLast[2]);
         selErrCount4 += int'(selErr);
         if (traceOn) trace.push_back({outValid, outLast});
      end
   end

   // Output monitor for the 3-lane instance.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (outValid3[i] && outReady3[i]) begin
               checkOutput("sb3_has_entry", sb3.size() != 0, 1);
               if (sb3.size() != 0) begin
                  exp3 = sb3.pop_front();
                  checkOutput("sb3_lane", i, exp3.lane);
                  checkOutput("sb3_data", outData3[i*8 +: 8], exp3.data);
                  checkOutput("sb3_last", outLast3[i], exp3.last);
               end
            end
            if (!outValid3[i]) begin
               checkOutput("idle_data3", outData3[i*8 +: 8], 0);
            end
         end
         selErrCount3 += int'(selErr3);
         validCount3  += int'(outValid3 != 0);
      end
   end

   initial begin
      int  firstIdx;
      bit  found;
      logic [3:0] oneHot;

      rst_n = 1'b0;
      idleInputs();
      outReady  = 4'hF;
      outReady3 = 3'h7;

      // Reset state, sampled while reset is held.
      @(negedge clk);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_data", outData, 0);
      checkOutput("rst_out_last", outLast, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_sel_err", selErr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_in_ready3", inReady3, 1);
      checkOutput("rst_busy_after", busy, 0);
      @(posedge clk); #1;

      $display("[TB] 3-beat packet to lane 2");
      busyCycles4 = 0; lane2Valid4 = 0; lane2Last4 = 0;
      applyStimulus(8'h11, 2'd2, 1'b0, 4'd2);
      applyStimulus(8'h22, 2'd2, 1'b0, 4'd2);
      applyStimulus(8'h33, 2'd2, 1'b1, 4'd2);
      idleInputs();
      waitCycles(3);
      checkOutput("t1_busy_cycles", busyCycles4, 2);
      checkOutput("t1_lane2_valid_cycles", lane2Valid4, 3);
      checkOutput("t1_lane2_last_cycles", lane2Last4, 1);

      $display("[TB] 4-beat packet to lane 1 with in_sel toggling");
      applyStimulus(8'h41, 2'd1, 1'b0, 4'd1);
      applyStimulus(8'h42, 2'd3, 1'b0, 4'd1);
      applyStimulus(8'h43, 2'd3, 1'b0, 4'd1);
      applyStimulus(8'h44, 2'd3, 1'b1, 4'd1);
      idleInputs();
      waitCycles(2);

      $display("[TB] lane 0 backpressure");
      outReady = 4'b1110;
      applyStimulus(8'h55, 2'd0, 1'b0, 4'd0);
      inData = 8'h66; inSel = 2'd0; inLast = 1'b0; inValid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t3_in_ready_stall", inReady, 0);
         checkOutput("t3_out_valid_stall", outValid, 4'b0001);
         checkOutput("t3_held_data", outData[7:0], 8'h55);
      end
      @(posedge clk); #1;
      outReady = 4'hF;
      applyStimulus(8'h66, 2'd0, 1'b0, 4'd0);
      applyStimulus(8'h77, 2'd0, 1'b1, 4'd0);
      idleInputs();
      waitCycles(3);

      $display("[TB] out-of-range select on 3-lane instance");
      selErrCount3 = 0; validCount3 = 0;
      applyStimulus3(8'hA1, 2'd3, 1'b0, 4'd0, 1'b1);
      @(negedge clk);
      checkOutput("t4_drop_in_ready", inReady3, 1);
      checkOutput("t4_drop_busy", busy3, 1);
      @(posedge clk); #1;
      applyStimulus3(8'hA2, 2'd3, 1'b1, 4'd0, 1'b1);
      idleInputs();
      waitCycles(3);
      checkOutput("t4_sel_err_pulses", selErrCount3, 1);
      checkOutput("t4_no_out_valid", validCount3, 0);
      checkOutput("t4_busy_cleared", busy3, 0);
      applyStimulus3(8'hB1, 2'd2, 1'b0, 4'd2, 1'b0);
      applyStimulus3(8'hB2, 2'd2, 1'b1, 4'd2, 1'b0);
      idleInputs();
      waitCycles(3);

      $display("[TB] back-to-back single-beat packets");
      trace.delete();
      traceOn = 1;
      applyStimulus(8'hE0, 2'd0, 1'b1, 4'd0);
      applyStimulus(8'hE1, 2'd1, 1'b1, 4'd1);
      applyStimulus(8'hE2, 2'd2, 1'b1, 4'd2);
      applyStimulus(8'hE3, 2'd3, 1'b1, 4'd3);
      idleInputs();
      waitCycles(3);
      traceOn = 0;
      found = 0;
      firstIdx = 0;
      for (int k = 0; k < trace.size(); k++) begin
         if (!found && trace[k] != 8'h00) begin
            found = 1;
            firstIdx = k;
         end
      end
      checkOutput("t5_trace_found", found && (firstIdx + 3 < trace.size()), 1);
      if (found && (firstIdx + 3 < trace.size())) begin
         for (int j = 0; j < 4; j++) begin
            oneHot = 4'(1 << j);
            checkOutput("t5_onehot_seq", trace[firstIdx + j], {oneHot, oneHot});
         end
      end
      checkOutput("t4_sel_err_never4", selErrCount4, 0);

      $display("[TB] reset mid-packet");
      outReady = 4'b1011;
      applyStimulus(8'hC1, 2'd2, 1'b0, 4'd2);
      inData = 8'hC2; inSel = 2'd2; inLast = 1'b0; inValid = 1'b1;
      @(negedge clk);
      checkOutput("t6_pre_valid", outValid, 4'b0100);
      checkOutput("t6_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_valid", outValid, 0);
      checkOutput("t6_async_data", outData, 0);
      checkOutput("t6_async_busy", busy, 0);
      checkOutput("t6_async_in_ready", inReady, 1);
      sb4.delete();
      idleInputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      outReady = 4'hF;
      applyStimulus(8'hD1, 2'd3, 1'b0, 4'd3);
      applyStimulus(8'hD2, 2'd3, 1'b1, 4'd3);
      idleInputs();
      waitCycles(4);

      checkOutput("sb4_drained", sb4.size(), 0);
      checkOutput("sb3_drained", sb3.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
